// File: rtl/io_sequence_monitor_if.sv
// io_sequence_monitor_if
// Groups the configuration, run-control, observed-pin and status signals of
// io_sequence_monitor.
//   master : drives cfg_*, start, abort, io_in; observes status
//   slave  : the monitor itself
// Ports carried: cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_timeout, start,
// abort, io_in (towards the monitor); busy, pass, fail, fail_code, step_idx
// (from the monitor).
interface io_sequence_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT_W = 24
);
  localparam int AW = $clog2(DEPTH);

  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [WIDTH-1:0]     cfg_wdata;
  logic [AW:0]          cfg_len;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     io_in;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [1:0]           fail_code;
  logic [AW-1:0]        step_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_timeout, start, abort, io_in,
    input  busy, pass, fail, fail_code, step_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_len, cfg_timeout, start, abort, io_in,
    output busy, pass, fail, fail_code, step_idx
  );
endinterface

// File: rtl/io_sequence_monitor.sv
// io_sequence_monitor
// Watches a synchronized copy of io_in and checks that the programmed table of
// expected values appears in order, each step within a cycle budget.
// Ports:
//   clock  : system clock
//   resetb : asynchronous active-low reset
//   bus    : io_sequence_monitor_if.slave (table write port, cfg_len,
//            cfg_timeout, start/abort, io_in, and registered status outputs
//            busy/pass/fail/fail_code/step_idx)
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no run; waiting for start
// S_WAIT | run in progress, awaiting table[step_idx] on the pins
// S_PASS | every entry seen in order; holds until start/abort
// S_FAIL | timeout or bad length; holds until start/abort
module io_sequence_monitor #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_W    = 24,
  parameter int MATCH_CYCLES = 2
) (
  input logic                  clock,
  input logic                  resetb,
  io_sequence_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = (MATCH_CYCLES > 1) ? $clog2(MATCH_CYCLES) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_BADLEN  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sync1_q, sync_q;
  logic [WIDTH-1:0]     tbl [DEPTH];
  logic [AW-1:0]        step_q, step_d;
  logic [1:0]           code_q, code_d;
  logic [MW-1:0]        cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [AW:0]          len_q, len_d;
  logic                 busy_q, pass_q, fail_q;
  logic                 match, accept;

  // Pins are asynchronous to clock; only the second stage is ever compared.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= bus.io_in;
      sync_q  <= sync1_q;
    end
  end

  // Table is deliberately not reset; writes during a run are dropped.
  always_ff @(posedge clock) begin
    if (bus.cfg_we && !busy_q) tbl[bus.cfg_addr] <= bus.cfg_wdata;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    tmo_d   = tmo_q;
    len_d   = len_q;
    match   = (sync_q == tbl[step_q]);
    accept  = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      code_d  = CODE_NONE;
      cnt_d   = '0;
      timer_d = '0;
    end else if (state_q == S_WAIT) begin
      if (match) begin
        if (cnt_q == MATCH_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
          if ({1'b0, step_q} == len_q - (AW + 1)'(1)) state_d = S_PASS;
          else                                         step_d  = step_q + AW'(1);
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end else begin
        cnt_d = '0;
      end
      // A same-edge accept takes precedence over the timeout.
      if (!accept) begin
        if (tmo_q != '0 && timer_q == tmo_q - TIMEOUT_W'(1)) begin
          state_d = S_FAIL;
          code_d  = CODE_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
    end else if (bus.start) begin
      step_d  = '0;
      cnt_d   = '0;
      timer_d = '0;
      if (bus.cfg_len == '0 || bus.cfg_len > DEPTH_L) begin
        state_d = S_FAIL;
        code_d  = CODE_BADLEN;
      end else begin
        state_d = S_WAIT;
        code_d  = CODE_NONE;
        len_d   = bus.cfg_len;
        tmo_d   = bus.cfg_timeout;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      code_q  <= CODE_NONE;
      cnt_q   <= '0;
      timer_q <= '0;
      tmo_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
      len_q   <= len_d;
      busy_q  <= (state_d == S_WAIT);
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;
  assign bus.step_idx  = step_q;
endmodule
